// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: sequential fetch from a synchronous-read instruction
// memory into a DEPTH-entry {instr, pc} queue, drained to decode over valid/ready.
module prefetch_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 9,
    parameter int                  DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [PC_WIDTH-1:0]      out_pc_inc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_d [DEPTH];
    logic [PC_WIDTH-1:0]    pc_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc_d [DEPTH];

    logic                   valid_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   req_s;
    logic [CW:0]            occ_s;

    // Handshake, credit check and next-state computation for the fetch path and queue.
    always_comb begin
        valid_s = (count_q != '0) && !reset;
        pop_s   = valid_s && out_ready;
        push_s  = inflight_q && !redirect && !reset;
        // Occupancy the queue will reach once the outstanding read lands, net of this cycle's pop.
        occ_s   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
        req_s   = fetch_en && !redirect && !reset && (occ_s < (CW+1)'(DEPTH));

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        instr_d       = instr_q;
        pc_d          = pc_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_s) begin
                fetch_pc_d    = fetch_pc_q + PC_WIDTH'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                inflight_d    = 1'b0;
            end
            if (push_s) begin
                instr_d[wr_ptr_q] = imem_data;
                pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d          = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue payload storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign imem_req   = req_s;
    assign imem_addr  = fetch_pc_q;
    assign out_valid  = valid_s;
    assign out_instr  = instr_q[rd_ptr_q];
    assign out_pc     = pc_q[rd_ptr_q];
    assign out_pc_inc = pc_q[rd_ptr_q] + PC_WIDTH'(1);
    assign count      = count_q;

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [8:0]  imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_inc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    prefetch_unit #(
        .PC_WIDTH(16), .INSTR_WIDTH(9), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_inc(out_pc_inc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] rom(input logic [15:0] a);
        return a[8:0] ^ {2'b00, a[15:9]};
    endfunction

    // Synchronous-read memory; returns garbage when not requested.
    always @(posedge clk) begin
        if (imem_req) imem_data <= rom(imem_addr);
        else          imem_data <= 9'($urandom);
    end

    typedef struct packed {
        logic [8:0]  instr;
        logic [15:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_fetch_pc = 16'h0000;
    bit          m_infl     = 1'b0;
    logic [15:0] m_infl_pc  = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input bit fe, input bit rdy, input bit rd, input logic [15:0] rpc, input bit rst);
        bit   exp_valid, exp_pop, exp_req;
        ent_t head;
        @(negedge clk);
        fetch_en    = fe;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        reset       = rst;
        #1;
        exp_valid = (m_q.size() > 0) && !rst;
        exp_pop   = exp_valid && rdy;
        exp_req   = fe && !rd && !rst && ((m_q.size() + int'(m_infl) - int'(exp_pop)) < DEPTH);
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("imem_req",  32'(imem_req),  32'(exp_req));
        check_eq("imem_addr", 32'(imem_addr), 32'(m_fetch_pc));
        check_eq("count",     32'(count),     32'(m_q.size()));
        if (exp_valid) begin
            head = m_q[0];
            check_eq("out_pc",     32'(out_pc),     32'(head.pc));
            check_eq("out_instr",  32'(out_instr),  32'(head.instr));
            check_eq("out_pc_inc", 32'(out_pc_inc), 32'(16'(head.pc + 16'd1)));
        end
        if (rst) begin
            m_q.delete();
            m_fetch_pc = 16'h0000;
            m_infl     = 1'b0;
        end else if (rd) begin
            m_q.delete();
            m_fetch_pc = rpc;
            m_infl     = 1'b0;
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back('{instr: rom(m_infl_pc), pc: m_infl_pc});
            if (exp_req) begin
                m_infl     = 1'b1;
                m_infl_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 16'd1;
            end else begin
                m_infl     = 1'b0;
            end
        end
    endtask

    initial begin
        int first_valid;
        reset       = 1'b1;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b0;

        // Reset and streaming: first valid output two cycles after the first request.
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
            if (i == 0) check_eq("first_addr", 32'(imem_addr), 32'h0);
            if (out_valid && first_valid < 0) first_valid = i;
            if (i >= 2) check_eq("stream_pc", 32'(out_pc), 32'(i - 2));
        end
        check_eq("first_valid_cycle", 32'(first_valid), 32'd2);

        // Redirect mid-stream, coincident with a pop.
        step(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("redir_r1_valid", 32'(out_valid), 32'h0);
        check_eq("redir_r1_count", 32'(count), 32'h0);
        check_eq("redir_r1_addr",  32'(imem_addr), 32'h0100);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("redir_r2_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("redir_r3_pc", 32'(out_pc), 32'h0100);

        // PC wrap through 0xFFFF.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("wrap_pc",     32'(out_pc),     32'hFFFF);
        check_eq("wrap_pc_inc", 32'(out_pc_inc), 32'h0000);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("wrap_next_pc", 32'(out_pc), 32'h0000);

        // Backpressure from reset: queue fills to DEPTH, then drains 0..3 in order.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_eq("bp_count", 32'(count), 32'd4);
        check_eq("bp_req",   32'(imem_req), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
            if (i == 0) check_eq("bp_req_release", 32'(imem_req), 32'h1);
            check_eq("bp_drain_pc", 32'(out_pc), 32'(i));
        end

        // fetch_en drop with one read in flight, then reset with queue non-empty.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_eq("fe_drop_count", 32'(count), 32'd1);
        check_eq("fe_drop_req",   32'(imem_req), 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_addr",  32'(imem_addr), 32'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom),
                 ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
